// File: rtl/mem_dump_reader.sv
// mem_dump_reader: sweeps a word-aligned memory window through the core's back-door
// read port and streams each word out on valid/ready with a running checksum.
module mem_dump_reader #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [15:0] word_count_i,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_data_i,
    output logic        dump_valid_o,
    input  logic        dump_ready_i,
    output logic [31:0] dump_data_o,
    output logic [31:0] dump_addr_o,
    output logic        dump_last_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] checksum_o
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DONE} state_t;
    localparam logic [1:0] CNT_INIT = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);
    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, data_q, data_d, csum_q, csum_d;
    logic [15:0] rem_q, rem_d;
    logic [1:0]  cnt_q, cnt_d;
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            csum_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            csum_q  <= csum_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        csum_d  = csum_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start_i) begin
                csum_d = '0;
                if (word_count_i != 16'd0) begin
                    addr_d  = base_addr_i & ~32'd3;
                    rem_d   = word_count_i;
                    state_d = ISSUE;
                end else begin
                    state_d = DONE;
                end
            end
            ISSUE: if (READ_LATENCY == 0) begin
                data_d  = mem_data_i;
                state_d = HOLD;
            end else begin
                cnt_d   = CNT_INIT;
                state_d = WAIT;
            end
            WAIT: if (cnt_q == 2'd0) begin
                data_d  = mem_data_i;
                state_d = HOLD;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
            HOLD: if (dump_ready_i) begin
                csum_d = csum_q + data_q;
                if (rem_q == 16'd1) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + 32'd4;
                    rem_d   = rem_q - 16'd1;
                    state_d = ISSUE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // The read address stays on the bus through HOLD so the core sees a stable request.
    assign busy_o       = state_q inside {ISSUE, WAIT, HOLD};
    assign mem_addr_o   = busy_o ? addr_q : '0;
    assign dump_valid_o = state_q == HOLD;
    assign dump_data_o  = dump_valid_o ? data_q : '0;
    assign dump_addr_o  = dump_valid_o ? addr_q : '0;
    assign dump_last_o  = dump_valid_o && rem_q == 16'd1;
    assign done_o       = state_q == DONE;
    assign checksum_o   = csum_q;
endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader: runs a table of dump windows on three latency variants in parallel,
// plus a reset-abort sequence, checking stream contents, timing and checksum.
module tb_mem_dump_reader;
    localparam int NI = 3;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [31:0] base = '0;
    logic [15:0] cnt = '0;
    logic [31:0] m_addr [NI], m_data [NI], d_data [NI], d_addr [NI], csum [NI];
    logic        valid [NI], last [NI], busy [NI], done [NI], rdy [NI];
    int          n_cmp = 0, n_err = 0;
    int          stall_idx = -1, stall_len = 0;
    always #5 clk = ~clk;

    function automatic int lat(input int g);
        return g == 0 ? 1 : g == 1 ? 0 : 3;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h100:      return 32'h11;
            32'h104:      return 32'h22;
            32'h108:      return 32'h33;
            32'h10C:      return 32'h44;
            32'h200:      return 32'h1000;
            32'h204:      return 32'h2000;
            32'h208:      return 32'h3000;
            32'h20C:      return 32'h4000;
            32'hFFFFFFFC: return 32'hDEAD0000;
            32'h0:        return 32'h0000BEEF;
            default:      return 32'hA5A5A5A5;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int L  = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        localparam int PI = (L == 0) ? 0 : L - 1;
        logic [31:0] pipe [3];
        always @(posedge clk) begin
            pipe[0] <= m_addr[g];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign m_data[g] = mem_rd(L == 0 ? m_addr[g] : pipe[PI]);
        mem_dump_reader #(.READ_LATENCY(L)) dut (
            .clk(clk), .rstn_i(rst_n), .start_i(start), .base_addr_i(base),
            .word_count_i(cnt), .mem_addr_o(m_addr[g]), .mem_data_i(m_data[g]),
            .dump_valid_o(valid[g]), .dump_ready_i(rdy[g]), .dump_data_o(d_data[g]),
            .dump_addr_o(d_addr[g]), .dump_last_o(last[g]), .busy_o(busy[g]),
            .done_o(done[g]), .checksum_o(csum[g])
        );
    end

    int          cyc = 0, start_cyc = 0;
    int          hs_n [NI], scnt [NI], done_n [NI], done_cyc [NI], stab_err [NI], drop_err [NI];
    int          hs_cyc [NI][8];
    logic [31:0] hs_addr [NI][8], hs_data [NI][8];
    logic        hs_last [NI][8];
    logic        busy_seen [NI], pv [NI], phs [NI], p_last [NI];
    logic [31:0] p_data [NI], p_addr [NI], p_maddr [NI], p_csum [NI];

    always_comb
        for (int g = 0; g < NI; g++) rdy[g] = !(hs_n[g] == stall_idx && scnt[g] < stall_len);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (start) start_cyc <= cyc;
        for (int g = 0; g < NI; g++) begin
            if (pv[g] === 1'b1 && phs[g] === 1'b0 && rst_n) begin
                if (!valid[g]) drop_err[g] <= drop_err[g] + 1;
                else if (d_data[g] != p_data[g] || d_addr[g] != p_addr[g] || last[g] != p_last[g]
                         || m_addr[g] != p_maddr[g] || csum[g] != p_csum[g])
                    stab_err[g] <= stab_err[g] + 1;
            end
            pv[g] <= valid[g];
            phs[g] <= valid[g] && rdy[g];
            p_data[g] <= d_data[g];
            p_addr[g] <= d_addr[g];
            p_last[g] <= last[g];
            p_maddr[g] <= m_addr[g];
            p_csum[g] <= csum[g];
            if (start) begin
                hs_n[g] <= 0; scnt[g] <= 0; done_n[g] <= 0;
                busy_seen[g] <= 1'b0; stab_err[g] <= 0; drop_err[g] <= 0;
            end else begin
                if (valid[g] && rdy[g]) begin
                    if (hs_n[g] < 8) begin
                        hs_cyc[g][hs_n[g]] <= cyc;
                        hs_addr[g][hs_n[g]] <= d_addr[g];
                        hs_data[g][hs_n[g]] <= d_data[g];
                        hs_last[g][hs_n[g]] <= last[g];
                    end
                    hs_n[g] <= hs_n[g] + 1;
                end
                if (valid[g] && !rdy[g]) scnt[g] <= scnt[g] + 1;
                if (done[g]) begin
                    done_n[g] <= done_n[g] + 1;
                    done_cyc[g] <= cyc;
                end
                if (busy[g]) busy_seen[g] <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int g = 0; g < NI; g++)
            chk($sformatf("%s outputs zero L=%0d", tag, lat(g)),
                d_data[g] | d_addr[g] | m_addr[g] | csum[g] | {28'b0, valid[g], last[g], busy[g], done[g]}, 32'h0);
    endtask

    typedef struct {
        logic [31:0] base;
        logic [15:0] count;
        int          stall_idx;
        int          stall_len;
        logic [31:0] first_addr;
        logic [31:0] last_addr;
        logic [31:0] sum;
    } vec_t;
    vec_t vt [7];

    task automatic run_vec(input vec_t v, input int idx);
        int t;
        int all_done;
        stall_idx = v.stall_idx;
        stall_len = v.stall_len;
        @(negedge clk);
        base = v.base; cnt = v.count; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        all_done = 0;
        while (!all_done && t < 300) begin
            @(negedge clk);
            t++;
            all_done = 1;
            for (int g = 0; g < NI; g++) if (done_n[g] < 1) all_done = 0;
        end
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d completed in time", idx), 32'(all_done), 32'd1);
        for (int g = 0; g < NI; g++) begin
            int l = lat(g);
            string s = $sformatf("v%0d L=%0d", idx, l);
            chk({s, " words"}, 32'(hs_n[g]), 32'(v.count));
            for (int k = 0; k < int'(v.count) && k < 8; k++) begin
                logic [31:0] a = (v.base & ~32'd3) + 32'(4 * k);
                int pc = (k == 0) ? start_cyc : hs_cyc[g][k - 1];
                chk($sformatf("%s addr[%0d]", s, k), hs_addr[g][k], a);
                chk($sformatf("%s data[%0d]", s, k), hs_data[g][k], mem_rd(a));
                chk($sformatf("%s last[%0d]", s, k), 32'(hs_last[g][k]), 32'(k == int'(v.count) - 1));
                chk($sformatf("%s timing[%0d]", s, k), 32'(hs_cyc[g][k] - pc),
                    32'(l + 2 + (k == v.stall_idx ? v.stall_len : 0)));
            end
            if (v.count != 16'd0) begin
                chk({s, " first addr"}, hs_addr[g][0], v.first_addr);
                chk({s, " last addr"}, hs_addr[g][v.count - 16'd1], v.last_addr);
            end
            chk({s, " done pulses"}, 32'(done_n[g]), 32'd1);
            chk({s, " done cycle"}, 32'(done_cyc[g]),
                32'((v.count == 16'd0 ? start_cyc : hs_cyc[g][v.count - 16'd1]) + 1));
            chk({s, " checksum"}, csum[g], v.sum);
            chk({s, " stability"}, 32'(stab_err[g]), 32'd0);
            chk({s, " valid drop"}, 32'(drop_err[g]), 32'd0);
            chk({s, " busy seen"}, 32'(busy_seen[g]), 32'(v.count != 16'd0));
            chk({s, " idle addr/busy"}, m_addr[g] | {31'b0, busy[g]}, 32'h0);
        end
    endtask

    initial begin
        int t;
        vt[0] = '{32'h100,      16'd3, -1, 0, 32'h100,      32'h108, 32'h66};
        vt[1] = '{32'h100,      16'd3,  1, 5, 32'h100,      32'h108, 32'h66};
        vt[2] = '{32'h0,        16'd0, -1, 0, 32'h0,        32'h0,   32'h0};
        vt[3] = '{32'h103,      16'd1, -1, 0, 32'h100,      32'h100, 32'h11};
        vt[4] = '{32'hFFFFFFFC, 16'd2, -1, 0, 32'hFFFFFFFC, 32'h0,   32'hDEADBEEF};
        vt[5] = '{32'h200,      16'd4,  3, 2, 32'h200,      32'h20C, 32'hA000};
        vt[6] = '{32'h10E,      16'd2, -1, 0, 32'h10C,      32'h110, 32'hA5A5A5E9};
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 7; i++) run_vec(vt[i], i);
        // Abort a dump with reset while the L=1 instance holds word 2 of 4.
        stall_idx = -1;
        stall_len = 0;
        @(negedge clk);
        base = 32'h200; cnt = 16'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!(hs_n[0] == 1 && valid[0]) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("abort reached word 2 hold", 32'(t < 100), 32'd1);
        chk("abort valid before reset", d_addr[0], 32'h204);
        rst_n = 1'b0;
        #1;
        chk_zero("abort reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("abort no done L=%0d", lat(g)), 32'(done_n[g]), 32'd0);
            chk($sformatf("abort stays idle L=%0d", lat(g)), {30'b0, valid[g], busy[g]}, 32'h0);
        end
        run_vec(vt[0], 7);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
